const_load_ctrl: RTL and testbench
==================================

Name: const_load_ctrl

Overview:
Sequencer for the immediate-constant extender and its register-file write-back on the 16-bit core. It accepts one constant-load micro-op (loadlit / lch / lcl) from the decoder and drives the extender control and constant fields. For lch/lcl it performs a read-modify-write of the destination register. It shares the register-file read and write ports with other requesters through request/grant handshakes, with a grant timeout.

Parameters:
REG_AW, 4, register index width (16 registers)
GNT_TIMEOUT, 15, max cycles waiting on any grant before abort; legal range 1..255

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decoder presents a constant-load op
in_ready  out  1  high only in IDLE
in_op  in  2  00 loadlit, 01 lcl, 10 lch, 11 reserved
in_dst  in  REG_AW  destination register
in_const  in  11  raw instruction constant field
ext_ctrl  out  2  extender control: 00 sign-ext 11b, 01 zero-ext, 10 byte-to-high
ext_const  out  11  constant to extender
ext_value  in  16  extender result (combinational from ext_ctrl/ext_const)
rf_rd_req  out  1  read-port request
rf_rd_gnt  in  1  read-port grant
rf_rd_addr  out  REG_AW  read address
rf_rd_data  in  16  valid the cycle after rf_rd_req&rf_rd_gnt
rf_wr_req  out  1  write-port request; write occurs on rf_wr_req&rf_wr_gnt
rf_wr_gnt  in  1  write-port grant
rf_wr_addr  out  REG_AW  write address
rf_wr_data  out  16  write data
done  out  1  one-cycle pulse after successful write
err  out  1  one-cycle pulse on reserved op or timeout

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1; internal regs and timeout counter cleared. Reset mid-operation abandons the op with no write and no done/err.
- IDLE: in_ready=1. On in_valid: latch op/dst/const. op=11 -> err pulse next cycle, remain IDLE. Otherwise -> EXT.
- EXT (1 cycle): ext_const=latched const; ext_ctrl=00 for loadlit, 01 for lcl, 10 for lch. Register ext_value at the end of the cycle. loadlit -> WRITE; lcl/lch -> READ. ext_ctrl/ext_const are 0 outside EXT.
- READ: rf_rd_req=1, rf_rd_addr=dst. On grant -> RDATA. Otherwise increment the wait counter.
- RDATA (1 cycle): capture rf_rd_data, merge it with the registered ext value, -> WRITE.
  - lcl: result = {rd[15:8], ext[7:0]}.
  - lch: result = {ext[15:8], rd[7:0]}.
- WRITE: rf_wr_req=1, addr=dst, data=result (loadlit: ext_value as registered). On grant -> IDLE; done=1 in the following cycle. in_ready is already 1 that cycle, so a back-to-back accept is allowed.
- Timeout: the wait counter clears on entry to READ/WRITE and counts cycles without grant. When it reaches GNT_TIMEOUT without grant: drop the request, go to IDLE, err=1 next cycle, no write.
- A grant arriving in the same cycle the counter hits the limit wins: the handshake completes, no error.
- Minimum latency from accept (cycle 0) to done:
  - loadlit: done at cycle 3.
  - lch/lcl: done at cycle 5.
- rf_rd_req and rf_wr_req are never both high. Requests are held stable until granted or timed out.
- done and err are never both high.

Decomposition:
- Shared package const_load_pkg holds:
  - op enum: OP_LOADLIT=00, OP_LCL=01, OP_LCH=10, OP_RSVD=11.
  - ext-control enum: EXT_SEXT11=00, EXT_ZEXT=01, EXT_HIBYTE=10.
  - FSM state enum: IDLE, EXT, READ, RDATA, WRITE.
- One natural sub-module is gnt_wait_timer: a counter with clear, enable and expired outputs, reused for both grant waits.

Test Plan:
- loadlit, const=11'h7FF, dst=3, grants tied high -> ext_ctrl=00 in EXT; write r3=16'hFFFF; done at cycle 3.
- lcl, const=11'h0AB, dst=5, rf_rd_data=16'h1234 -> read r5; write r5=16'h12AB; done at cycle 5.
- lch, const=11'h0CD, dst=2, rf_rd_data=16'h1234 -> ext_ctrl=10; write r2=16'hCD34.
- loadlit with rf_wr_gnt held low for 15 cycles -> err pulse, rf_wr_req drops, no write. Repeat with grant arriving on the 15th cycle -> write completes, no err.
- in_op=11 -> err pulse next cycle, no rf requests, in_ready stays 1. Then a loadlit accepted in the cycle a previous done pulses -> both ops complete in order.
- reset asserted while in READ -> next cycle state IDLE, rf_rd_req=0, no done/err, in_ready=1.

Source files
------------

// File: rtl/const_load_pkg.sv
// Shared types for the constant-load sequencer: micro-op codes, extender
// control codes, FSM states and the op-to-extender mapping.
package const_load_pkg;

  typedef enum logic [1:0] {
    OP_LOADLIT = 2'b00,
    OP_LCL     = 2'b01,
    OP_LCH     = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    EXT_SEXT11 = 2'b00,
    EXT_ZEXT   = 2'b01,
    EXT_HIBYTE = 2'b10
  } ext_ctrl_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXT   = 3'd1,
    READ  = 3'd2,
    RDATA = 3'd3,
    WRITE = 3'd4
  } state_e;

  // Wide enough for the largest legal grant timeout (255).
  localparam int TIMER_W = 8;

  // loadlit needs the full signed 11-bit constant, lcl a zero-extended low
  // byte, lch the low constant byte moved into the high byte.
  function automatic ext_ctrl_e op_to_ext(op_e op);
    ext_ctrl_e ctrl;
    case (op)
      OP_LCL:  ctrl = EXT_ZEXT;
      OP_LCH:  ctrl = EXT_HIBYTE;
      default: ctrl = EXT_SEXT11;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/const_load_ctrl_gnt_wait_timer.sv
// Grant wait timer: counts consecutive cycles a request goes ungranted and
// flags the last cycle before the limit is reached.
module gnt_wait_timer
  import const_load_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] cnt;

  // Count ungranted cycles; saturate at the last value so it never wraps.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the LIMIT-th ungranted cycle; a grant in that same cycle
  // still takes priority in the controller.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/const_load_ctrl.sv
// Constant-load sequencer: drives the immediate extender for loadlit/lcl/lch
// and writes the result back to the register file, doing a read-modify-write
// of the destination for lcl/lch. Register-file ports are shared with other
// requesters through req/gnt handshakes guarded by a grant timeout.
module const_load_ctrl
  import const_load_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int GNT_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [10:0]       in_const,
  output logic [1:0]        ext_ctrl,
  output logic [10:0]       ext_const,
  input  logic [15:0]       ext_value,
  output logic              rf_rd_req,
  input  logic              rf_rd_gnt,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [15:0]       rf_rd_data,
  output logic              rf_wr_req,
  input  logic              rf_wr_gnt,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [15:0]       rf_wr_data,
  output logic              done,
  output logic              err
);

  state_e              state;
  op_e                 op_p0;
  logic [REG_AW-1:0]   dst_p0;
  logic [15:0]         ext_p1;

  logic                timer_en;
  logic                timer_clear;
  logic                timer_expired;

  // Merge the read-back register with the extended constant: lcl replaces
  // the low byte, lch replaces the high byte.
  function automatic logic [15:0] merge_rmw(op_e op, logic [15:0] rd,
                                            logic [15:0] ext);
    logic [15:0] res;
    if (op == OP_LCH) begin
      res = {ext[15:8], rd[7:0]};
    end else begin
      res = {rd[15:8], ext[7:0]};
    end
    return res;
  endfunction

  // The timer runs only while a request is outstanding and ungranted; any
  // other cycle (including the grant cycle) restarts it, so every READ or
  // WRITE entry begins counting from zero.
  assign timer_en    = ((state == READ)  && !rf_rd_gnt) ||
                       ((state == WRITE) && !rf_wr_gnt);
  assign timer_clear = !timer_en;

  gnt_wait_timer #(
    .LIMIT (GNT_TIMEOUT)
  ) u_gnt_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Sequencer FSM with all outputs registered; done/err are one-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      op_p0      <= OP_LOADLIT;
      dst_p0     <= '0;
      ext_p1     <= '0;
      ext_ctrl   <= '0;
      ext_const  <= '0;
      rf_rd_req  <= 1'b0;
      rf_rd_addr <= '0;
      rf_wr_req  <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_p0  <= op_e'(in_op);
            dst_p0 <= in_dst;
            if (op_e'(in_op) == OP_RSVD) begin
              err <= 1'b1;
            end else begin
              state     <= EXT;
              in_ready  <= 1'b0;
              ext_ctrl  <= op_to_ext(op_e'(in_op));
              ext_const <= in_const;
            end
          end
        end

        EXT: begin
          ext_p1    <= ext_value;
          ext_ctrl  <= '0;
          ext_const <= '0;
          if (op_p0 == OP_LOADLIT) begin
            state      <= WRITE;
            rf_wr_req  <= 1'b1;
            rf_wr_addr <= dst_p0;
            rf_wr_data <= ext_value;
          end else begin
            state      <= READ;
            rf_rd_req  <= 1'b1;
            rf_rd_addr <= dst_p0;
          end
        end

        READ: begin
          if (rf_rd_gnt) begin
            state      <= RDATA;
            rf_rd_req  <= 1'b0;
            rf_rd_addr <= '0;
          end else if (timer_expired) begin
            state      <= IDLE;
            rf_rd_req  <= 1'b0;
            rf_rd_addr <= '0;
            in_ready   <= 1'b1;
            err        <= 1'b1;
          end
        end

        RDATA: begin
          state      <= WRITE;
          rf_wr_req  <= 1'b1;
          rf_wr_addr <= dst_p0;
          rf_wr_data <= merge_rmw(op_p0, rf_rd_data, ext_p1);
        end

        WRITE: begin
          if (rf_wr_gnt) begin
            state      <= IDLE;
            rf_wr_req  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            in_ready   <= 1'b1;
            done       <= 1'b1;
          end else if (timer_expired) begin
            state      <= IDLE;
            rf_wr_req  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            in_ready   <= 1'b1;
            err        <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          rf_rd_req  <= 1'b0;
          rf_wr_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_load_ctrl.sv
// Directed bench for const_load_ctrl with a behavioural extender and
// register-file model.
module tb_const_load_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_dst;
  logic [10:0] in_const;
  logic [1:0]  ext_ctrl;
  logic [10:0] ext_const;
  logic [15:0] ext_value;
  logic        rf_rd_req;
  logic        rf_rd_gnt;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        rf_wr_req;
  logic        rf_wr_gnt;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rf_model [16] = '{default: 16'hDEAD};
  int          wr_count = 0;

  const_load_ctrl #(.REG_AW(4), .GNT_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dst(in_dst), .in_const(in_const),
    .ext_ctrl(ext_ctrl), .ext_const(ext_const), .ext_value(ext_value),
    .rf_rd_req(rf_rd_req), .rf_rd_gnt(rf_rd_gnt), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .rf_wr_req(rf_wr_req), .rf_wr_gnt(rf_wr_gnt), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Extender model: sign-extend 11b, zero-extend, or low byte to high byte.
  always_comb begin
    ext_value = 16'h0000;
    case (ext_ctrl)
      2'b00:   ext_value = {{5{ext_const[10]}}, ext_const};
      2'b01:   ext_value = {5'b0, ext_const};
      2'b10:   ext_value = {ext_const[7:0], 8'h00};
      default: ext_value = 16'h0000;
    endcase
  end

  // Register-file write port model.
  always @(posedge clock) begin
    if (!reset && rf_wr_req && rf_wr_gnt) begin
      rf_model[rf_wr_addr] = rf_wr_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [3:0] dst,
                        input logic [10:0] c);
    in_valid = 1'b1; in_op = op; in_dst = dst; in_const = c;
    tick();
    in_valid = 1'b0; in_op = 2'b00; in_dst = 4'h0; in_const = 11'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({rf_rd_req, rf_wr_req} !== 2'b00) begin failures++; $display("FAIL reset_reqs got=%b exp=00", {rf_rd_req, rf_wr_req}); end
    checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
    checks++; if ({ext_ctrl, ext_const, rf_wr_data} !== 29'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {ext_ctrl, ext_const, rf_wr_data}); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_loadlit();
    int w0;
    w0 = wr_count;
    accept(2'b00, 4'd3, 11'h7FF);
    checks++; if (ext_ctrl !== 2'b00 || ext_const !== 11'h7FF) begin failures++; $display("FAIL loadlit_ext got=%b/%h exp=00/7ff", ext_ctrl, ext_const); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL loadlit_busy got=%b exp=0", in_ready); end
    tick();
    checks++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 4'd3 || rf_wr_data !== 16'hFFFF) begin failures++; $display("FAIL loadlit_wr got=%b/%h/%h exp=1/3/ffff", rf_wr_req, rf_wr_addr, rf_wr_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL loadlit_early_done got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL loadlit_done_c3 got=%b/%b exp=1/0", done, err); end
    checks++; if (rf_model[3] !== 16'hFFFF || wr_count !== w0 + 1) begin failures++; $display("FAIL loadlit_rf got=%h/%0d exp=ffff/%0d", rf_model[3], wr_count, w0 + 1); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL loadlit_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_lcl();
    rf_rd_data = 16'h1234;
    accept(2'b01, 4'd5, 11'h0AB);
    checks++; if (ext_ctrl !== 2'b01) begin failures++; $display("FAIL lcl_ext_ctrl got=%b exp=01", ext_ctrl); end
    tick();
    checks++; if (rf_rd_req !== 1'b1 || rf_rd_addr !== 4'd5 || rf_wr_req !== 1'b0) begin failures++; $display("FAIL lcl_rd got=%b/%h/%b exp=1/5/0", rf_rd_req, rf_rd_addr, rf_wr_req); end
    tick();
    checks++; if (rf_rd_req !== 1'b0 || rf_wr_req !== 1'b0) begin failures++; $display("FAIL lcl_rdata_reqs got=%b%b exp=00", rf_rd_req, rf_wr_req); end
    tick();
    checks++; if (rf_wr_req !== 1'b1 || rf_wr_addr !== 4'd5 || rf_wr_data !== 16'h12AB) begin failures++; $display("FAIL lcl_wr got=%b/%h/%h exp=1/5/12ab", rf_wr_req, rf_wr_addr, rf_wr_data); end
    tick();
    checks++; if (done !== 1'b1 || rf_model[5] !== 16'h12AB) begin failures++; $display("FAIL lcl_done_c5 got=%b/%h exp=1/12ab", done, rf_model[5]); end
  endtask

  task automatic test_lch();
    rf_rd_data = 16'h1234;
    accept(2'b10, 4'd2, 11'h0CD);
    checks++; if (ext_ctrl !== 2'b10 || ext_const !== 11'h0CD) begin failures++; $display("FAIL lch_ext got=%b/%h exp=10/0cd", ext_ctrl, ext_const); end
    tick(); tick(); tick();
    checks++; if (rf_wr_req !== 1'b1 || rf_wr_data !== 16'hCD34) begin failures++; $display("FAIL lch_wr got=%b/%h exp=1/cd34", rf_wr_req, rf_wr_data); end
    tick();
    checks++; if (done !== 1'b1 || rf_model[2] !== 16'hCD34) begin failures++; $display("FAIL lch_done got=%b/%h exp=1/cd34", done, rf_model[2]); end
  endtask

  task automatic test_wr_timeout();
    int w0;
    w0 = wr_count;
    rf_wr_gnt = 1'b0;
    accept(2'b00, 4'd7, 11'h005);
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (rf_wr_req !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL tmo_req_held got=%b/%b exp=1/0", rf_wr_req, err); end
    tick();
    checks++; if (err !== 1'b1 || done !== 1'b0 || rf_wr_req !== 1'b0) begin failures++; $display("FAIL tmo_err got=%b/%b/%b exp=1/0/0", err, done, rf_wr_req); end
    checks++; if (rf_model[7] !== 16'hDEAD || wr_count !== w0) begin failures++; $display("FAIL tmo_no_write got=%h/%0d exp=dead/%0d", rf_model[7], wr_count, w0); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse got=%b exp=0", err); end
    // Grant arrives in the 15th waiting cycle: handshake wins.
    accept(2'b00, 4'd7, 11'h400);
    tick();
    for (int i = 0; i < 14; i++) tick();
    rf_wr_gnt = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL tmo_late_gnt got=%b/%b exp=1/0", done, err); end
    checks++; if (rf_model[7] !== 16'hFC00) begin failures++; $display("FAIL tmo_late_rf got=%h exp=fc00", rf_model[7]); end
  endtask

  task automatic test_rsvd();
    accept(2'b11, 4'd1, 11'h123);
    checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rsvd_err got=%b/%b exp=1/0", err, done); end
    checks++; if (in_ready !== 1'b1 || rf_rd_req !== 1'b0 || rf_wr_req !== 1'b0 || ext_ctrl !== 2'b00) begin failures++; $display("FAIL rsvd_idle got=%b/%b/%b/%b exp=1/0/0/00", in_ready, rf_rd_req, rf_wr_req, ext_ctrl); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rsvd_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_count;
    accept(2'b00, 4'd4, 11'h010);
    tick(); tick();
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b/%b exp=1/1", done, in_ready); end
    accept(2'b00, 4'd6, 11'h7F0);
    checks++; if (ext_const !== 11'h7F0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%h/%b/%b exp=7f0/0/0", ext_const, in_ready, done); end
    tick(); tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    checks++; if (rf_model[4] !== 16'h0010 || rf_model[6] !== 16'hFFF0 || wr_count !== w0 + 2) begin failures++; $display("FAIL b2b_rf got=%h/%h/%0d exp=0010/fff0/%0d", rf_model[4], rf_model[6], wr_count, w0 + 2); end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_count;
    rf_rd_gnt = 1'b0;
    accept(2'b01, 4'd8, 11'h055);
    tick();
    checks++; if (rf_rd_req !== 1'b1) begin failures++; $display("FAIL mid_in_read got=%b exp=1", rf_rd_req); end
    reset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || rf_rd_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%b/%b/%b exp=1/0/0/0", in_ready, rf_rd_req, done, err); end
    reset = 1'b0;
    rf_rd_gnt = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b0 || err !== 1'b0 || rf_wr_req !== 1'b0 || wr_count !== w0) begin failures++; $display("FAIL mid_abandon got=%b/%b/%b/%0d exp=0/0/0/%0d", done, err, rf_wr_req, wr_count, w0); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_dst = 4'h0; in_const = 11'h0;
    rf_rd_gnt = 1'b1; rf_wr_gnt = 1'b1; rf_rd_data = 16'h0000;
    test_reset();
    test_loadlit();
    test_lcl();
    test_lch();
    test_wr_timeout();
    test_rsvd();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
